// File: rtl/healthcare_alarm_dispatcher.sv
// healthcare_alarm_dispatcher
// Qualifies upstream severity codes, latches an alarm, drives the buzzer and
// escalates to a nurse call when the alarm is left unacknowledged.
// Optional feature macro: ALARM_EVENT_COUNTER_EN builds the saturating
// eventCount register. Without it, eventCount is tied to 0.
module healthcare_alarm_dispatcher #(
   parameter int PERSIST_CYCLES = 4,
   parameter int ESC_CYCLES     = 16,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int BUZZ_DIV       = 2
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic [2:0] abnormalityWarning,
   input  logic       acknowledge,
   output logic       alarmActive,
   output logic [2:0] alarmCode,
   output logic       buzzer,
   output logic       nurseCall,
   output logic [7:0] eventCount
);

   localparam int QW = $clog2(PERSIST_CYCLES + 1);
   localparam int EW = $clog2(ESC_CYCLES + 1);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam int BW = $clog2(BUZZ_DIV + 1);

   localparam logic [QW-1:0] QUAL_LAST = QW'(PERSIST_CYCLES - 1);
   localparam logic [EW-1:0] ESC_LAST  = EW'(ESC_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      QUALIFY   = 3'd1,
      ALARM     = 3'd2,
      ESCALATED = 3'd3,
      HOLDOFF   = 3'd4
   } stateT;

   stateT         state, stateNext;
   logic [2:0]    code;
   logic [2:0]    qualCode, qualCodeNext;
   logic [QW-1:0] qualCnt, qualCntNext;
   logic [EW-1:0] escTimer, escTimerNext;
   logic [HW-1:0] holdTimer, holdTimerNext;
   logic [BW-1:0] buzzCnt, buzzCntNext;
   logic [2:0]    ackedCode, ackedCodeNext;
   logic          alarmActiveNext, buzzerNext, nurseCallNext;
   logic [2:0]    alarmCodeNext;
   logic          goAlarm, goQualify;
   logic [2:0]    newAlarmCode;

   // Code 7 is an out-of-range encoding and is folded onto the top severity.
   assign code = (abnormalityWarning == 3'd7) ? 3'd6 : abnormalityWarning;

   // Next-state and next-output logic; every register defaults to holding.
   always_comb begin
      stateNext       = state;
      qualCodeNext    = qualCode;
      qualCntNext     = qualCnt;
      escTimerNext    = escTimer;
      holdTimerNext   = holdTimer;
      buzzCntNext     = buzzCnt;
      ackedCodeNext   = ackedCode;
      alarmActiveNext = alarmActive;
      alarmCodeNext   = alarmCode;
      buzzerNext      = buzzer;
      nurseCallNext   = nurseCall;
      goAlarm         = 1'b0;
      goQualify       = 1'b0;
      newAlarmCode    = 3'd0;

      case (state)
         IDLE: begin
            if (code == 3'd6) begin
               goAlarm      = 1'b1;
               newAlarmCode = 3'd6;
            end else if (code != 3'd0) begin
               goQualify = 1'b1;
            end
         end
         QUALIFY: begin
            if (code == 3'd6) begin
               goAlarm      = 1'b1;
               newAlarmCode = 3'd6;
            end else if (code == 3'd0) begin
               stateNext   = IDLE;
               qualCntNext = '0;
            end else if (code != qualCode) begin
               goQualify = 1'b1;
            end else if (qualCnt == QUAL_LAST) begin
               goAlarm      = 1'b1;
               newAlarmCode = qualCode;
            end else begin
               qualCntNext = qualCnt + QW'(1);
            end
         end
         ALARM, ESCALATED: begin
            if (acknowledge) begin
               // Acknowledge beats a same-cycle upgrade: the code being
               // acknowledged is the one currently shown.
               stateNext       = HOLDOFF;
               ackedCodeNext   = alarmCode;
               holdTimerNext   = '0;
               escTimerNext    = '0;
               buzzCntNext     = '0;
               alarmActiveNext = 1'b0;
               alarmCodeNext   = 3'd0;
               buzzerNext      = 1'b0;
               nurseCallNext   = 1'b0;
            end else begin
               if (code > alarmCode) alarmCodeNext = code;
               if (state == ALARM) begin
                  if (escTimer == ESC_LAST) begin
                     stateNext     = ESCALATED;
                     nurseCallNext = 1'b1;
                     buzzerNext    = 1'b1;
                  end else begin
                     escTimerNext = escTimer + EW'(1);
                     if (buzzCnt == BUZZ_LAST) begin
                        buzzerNext  = ~buzzer;
                        buzzCntNext = '0;
                     end else begin
                        buzzCntNext = buzzCnt + BW'(1);
                     end
                  end
               end
            end
         end
         HOLDOFF: begin
            // Only a strictly higher code breaks the holdoff; re-raising the
            // acknowledged code (even 6) stays suppressed.
            if (code > ackedCode) begin
               if (code == 3'd6) begin
                  goAlarm      = 1'b1;
                  newAlarmCode = 3'd6;
               end else begin
                  goQualify = 1'b1;
               end
            end else if (holdTimer == HOLD_LAST) begin
               stateNext = IDLE;
            end else begin
               holdTimerNext = holdTimer + HW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase

      if (goQualify) begin
         stateNext    = QUALIFY;
         qualCodeNext = code;
         qualCntNext  = QW'(1);
      end

      if (goAlarm) begin
         stateNext       = ALARM;
         alarmActiveNext = 1'b1;
         alarmCodeNext   = newAlarmCode;
         buzzerNext      = 1'b1;
         buzzCntNext     = '0;
         escTimerNext    = '0;
         qualCntNext     = '0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         qualCode    <= 3'd0;
         qualCnt     <= '0;
         escTimer    <= '0;
         holdTimer   <= '0;
         buzzCnt     <= '0;
         ackedCode   <= 3'd0;
         alarmActive <= 1'b0;
         alarmCode   <= 3'd0;
         buzzer      <= 1'b0;
         nurseCall   <= 1'b0;
      end else begin
         state       <= stateNext;
         qualCode    <= qualCodeNext;
         qualCnt     <= qualCntNext;
         escTimer    <= escTimerNext;
         holdTimer   <= holdTimerNext;
         buzzCnt     <= buzzCntNext;
         ackedCode   <= ackedCodeNext;
         alarmActive <= alarmActiveNext;
         alarmCode   <= alarmCodeNext;
         buzzer      <= buzzerNext;
         nurseCall   <= nurseCallNext;
      end
   end

`ifdef ALARM_EVENT_COUNTER_EN
   logic       countEvent;
   logic [7:0] eventCnt;

   // An event is a fresh latch from a non-alarm state or an upgrade that
   // is not overridden by acknowledge.
   assign countEvent =
      (((state == IDLE) || (state == QUALIFY) || (state == HOLDOFF)) && goAlarm) ||
      (((state == ALARM) || (state == ESCALATED)) && !acknowledge && (code > alarmCode));

   // Saturating event counter.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)                              eventCnt <= 8'd0;
      else if (countEvent && eventCnt != 8'hFF) eventCnt <= eventCnt + 8'd1;
   end

   assign eventCount = eventCnt;
`else
   assign eventCount = 8'd0;
`endif

endmodule

// File: tb/tb_healthcare_alarm_dispatcher.sv
// Self-checking bench for healthcare_alarm_dispatcher: directed scenarios plus
// a randomized run compared against a behavioural model built on "time since
// latch" and "run length" bookkeeping.
module tb_healthcare_alarm_dispatcher;

   localparam int PERSIST = 4;
   localparam int ESC     = 16;
   localparam int HOLD    = 8;
   localparam int BUZZ    = 2;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic [2:0] abnormalityWarning = 3'd0;
   logic       acknowledge = 1'b0;
   logic       alarmActive;
   logic [2:0] alarmCode;
   logic       buzzer;
   logic       nurseCall;
   logic [7:0] eventCount;

   int checks = 0;
   int passes = 0;

   healthcare_alarm_dispatcher #(
      .PERSIST_CYCLES(PERSIST), .ESC_CYCLES(ESC),
      .HOLDOFF_CYCLES(HOLD), .BUZZ_DIV(BUZZ)
   ) dut (
      .clock(clock), .resetN(resetN),
      .abnormalityWarning(abnormalityWarning), .acknowledge(acknowledge),
      .alarmActive(alarmActive), .alarmCode(alarmCode), .buzzer(buzzer),
      .nurseCall(nurseCall), .eventCount(eventCount)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural reference model ----------------
   bit mLatched, mHold;
   int mCode, mAge, mAcked, mHoldAge, mRunCode, mRun, mEvents;

   function automatic void mdlReset();
      mLatched = 0; mHold = 0; mCode = 0; mAge = 0; mAcked = 0;
      mHoldAge = 0; mRunCode = 0; mRun = 0; mEvents = 0;
   endfunction

   function automatic void mdlLatch(int x);
      mLatched = 1; mCode = x; mAge = 0; mRun = 0; mHold = 0; mEvents++;
   endfunction

   function automatic void mdlStep(int w, bit a);
      int c;
      c = (w == 7) ? 6 : w;
      if (mLatched) begin
         if (a) begin
            mLatched = 0; mAcked = mCode; mHold = 1; mHoldAge = 0; mRun = 0;
         end else begin
            if (c > mCode) begin mCode = c; mEvents++; end
            mAge++;
         end
      end else if (mHold && c <= mAcked) begin
         mHoldAge++;
         if (mHoldAge >= HOLD) mHold = 0;
      end else begin
         mHold = 0;
         if (c == 6) mdlLatch(6);
         else if (c == 0) mRun = 0;
         else if (mRun > 0 && c == mRunCode) begin
            mRun++;
            if (mRun >= PERSIST) mdlLatch(mRunCode);
         end else begin
            mRunCode = c; mRun = 1;
         end
      end
   endfunction

   function automatic logic [7:0] expCount();
`ifdef ALARM_EVENT_COUNTER_EN
      return (mEvents > 255) ? 8'd255 : 8'(mEvents);
`else
      return 8'd0;
`endif
   endfunction

   // {alarmActive, alarmCode, buzzer, nurseCall, eventCount}
   function automatic logic [13:0] expVec();
      logic bz, nc;
      nc = mLatched && (mAge >= ESC);
      bz = mLatched && ((mAge >= ESC) || (((mAge / BUZZ) % 2) == 0));
      return {mLatched, (mLatched ? 3'(mCode) : 3'd0), bz, nc, expCount()};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic step(input int w, input bit a);
      abnormalityWarning = 3'(w);
      acknowledge = a;
      @(posedge clock);
      mdlStep(w, a);
      #1;
   endtask

   task automatic doReset();
      resetN = 1'b0;
      abnormalityWarning = 3'd0;
      acknowledge = 1'b0;
      mdlReset();
      @(posedge clock);
      #1;
      resetN = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetN = 1'b0;
      mdlReset();
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({alarmActive, alarmCode, buzzer, nurseCall, eventCount} !== 14'd0)
         $display("FAIL reset_outputs: got %h expected 0000",
                  {alarmActive, alarmCode, buzzer, nurseCall, eventCount});
      else passes++;
      resetN = 1'b1;
   endtask

   task automatic test_persistence();
      doReset();
      for (int i = 0; i < 3; i++) step(3, 0);
      step(0, 0);
      checks++;
      if (alarmActive !== 1'b0) $display("FAIL persist_short_run: alarmActive got %b expected 0", alarmActive);
      else passes++;
      for (int i = 1; i <= 4; i++) begin
         step(3, 0);
         checks++;
         if (alarmActive !== (i == 4)) $display("FAIL persist_sample%0d: alarmActive got %b expected %b", i, alarmActive, (i == 4));
         else passes++;
      end
      checks++;
      if (alarmCode !== 3'd3 || buzzer !== 1'b1) $display("FAIL persist_latch: code/buzzer got %0d/%b expected 3/1", alarmCode, buzzer);
      else passes++;
   endtask

   task automatic test_escalation();
      doReset();
      for (int i = 0; i < 4; i++) step(5, 0);
      for (int k = 1; k < ESC; k++) begin
         step(0, 0);
         checks++;
         if (nurseCall !== 1'b0 || buzzer !== (((k / BUZZ) % 2) == 0) || alarmCode !== 3'd5)
            $display("FAIL esc_alarm_k%0d: nurse/buzz/code got %b/%b/%0d expected 0/%b/5", k, nurseCall, buzzer, alarmCode, (((k / BUZZ) % 2) == 0));
         else passes++;
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 0);
         checks++;
         if (nurseCall !== 1'b1 || buzzer !== 1'b1 || alarmActive !== 1'b1)
            $display("FAIL esc_escalated%0d: nurse/buzz/active got %b/%b/%b expected 1/1/1", k, nurseCall, buzzer, alarmActive);
         else passes++;
      end
      step(0, 1);
      checks++;
      if ({alarmActive, alarmCode, buzzer, nurseCall} !== 6'd0)
         $display("FAIL esc_ack_clear: got %b expected 000000", {alarmActive, alarmCode, buzzer, nurseCall});
      else passes++;
   endtask

   task automatic test_upgrade();
      doReset();
      for (int i = 0; i < 4; i++) step(2, 0);
      step(4, 0);
      checks++;
      if (alarmCode !== 3'd4 || eventCount !== expCount())
         $display("FAIL upgrade_2_to_4: code/count got %0d/%0d expected 4/%0d", alarmCode, eventCount, expCount());
      else passes++;
`ifdef ALARM_EVENT_COUNTER_EN
      checks++;
      if (eventCount !== 8'd2) $display("FAIL upgrade_count: got %0d expected 2", eventCount);
      else passes++;
`endif
      step(3, 0);
      checks++;
      if (alarmCode !== 3'd4) $display("FAIL upgrade_lower_ignored: code got %0d expected 4", alarmCode);
      else passes++;
   endtask

   task automatic test_holdoff();
      doReset();
      for (int i = 0; i < 4; i++) step(4, 0);
      step(0, 1);
      for (int i = 0; i < 4; i++) step(4, 0);
      checks++;
      if (alarmActive !== 1'b0) $display("FAIL holdoff_same_suppressed: active got %b expected 0", alarmActive);
      else passes++;
      for (int i = 1; i <= 4; i++) begin
         step(5, 0);
         checks++;
         if (alarmActive !== (i == 4)) $display("FAIL holdoff_higher_s%0d: active got %b expected %b", i, alarmActive, (i == 4));
         else passes++;
      end
      checks++;
      if (alarmCode !== 3'd5) $display("FAIL holdoff_higher_code: got %0d expected 5", alarmCode);
      else passes++;
   endtask

   task automatic test_ack_wins();
      doReset();
      for (int i = 0; i < 4; i++) step(4, 0);
      step(6, 1);
      checks++;
      if ({alarmActive, alarmCode, buzzer, nurseCall, eventCount} !== expVec())
         $display("FAIL ackwins_clear: got %h expected %h", {alarmActive, alarmCode, buzzer, nurseCall, eventCount}, expVec());
      else passes++;
      // acked code must be 4, so a 5 qualifies and latches
      for (int i = 0; i < 4; i++) step(5, 0);
      checks++;
      if (alarmActive !== 1'b1 || alarmCode !== 3'd5)
         $display("FAIL ackwins_acked_code: active/code got %b/%0d expected 1/5", alarmActive, alarmCode);
      else passes++;
   endtask

   task automatic test_critical_reset();
      // inputs present while held in reset; nothing moves before an edge
      resetN = 1'b0;
      mdlReset();
      abnormalityWarning = 3'd6;
      @(posedge clock);
      #1;
      resetN = 1'b1;
      #2;
      checks++;
      if (alarmActive !== 1'b0) $display("FAIL release_no_early_change: active got %b expected 0", alarmActive);
      else passes++;
      step(6, 0);
      checks++;
      if (alarmActive !== 1'b1 || alarmCode !== 3'd6 || buzzer !== 1'b1)
         $display("FAIL critical_bypass: active/code/buzz got %b/%0d/%b expected 1/6/1", alarmActive, alarmCode, buzzer);
      else passes++;
      step(0, 0);
      checks++;
      if (alarmActive !== 1'b1 || alarmCode !== 3'd6) $display("FAIL critical_latched: active/code got %b/%0d expected 1/6", alarmActive, alarmCode);
      else passes++;
      #2;
      resetN = 1'b0;
      mdlReset();
      #1;
      checks++;
      if ({alarmActive, alarmCode, buzzer, nurseCall, eventCount} !== 14'd0)
         $display("FAIL async_reset_mid_alarm: got %h expected 0000", {alarmActive, alarmCode, buzzer, nurseCall, eventCount});
      else passes++;
      abnormalityWarning = 3'd0;
      @(posedge clock);
      #1;
      resetN = 1'b1;
      step(0, 0);
      checks++;
      if (alarmActive !== 1'b0) $display("FAIL reset_discards_alarm: active got %b expected 0", alarmActive);
      else passes++;
      step(7, 0);
      checks++;
      if (alarmCode !== 3'd6 || alarmActive !== 1'b1) $display("FAIL code7_as_6: code got %0d expected 6", alarmCode);
      else passes++;
   endtask

   task automatic test_random();
      int cur;
      bit a;
      int bad;
      doReset();
      cur = 0;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 9) < 2) cur = int'($urandom_range(0, 7));
         a = ($urandom_range(0, 11) == 0);
         step(cur, a);
         checks++;
         if ({alarmActive, alarmCode, buzzer, nurseCall, eventCount} !== expVec()) begin
            if (bad < 10)
               $display("FAIL random_cycle%0d: got %h expected %h (in=%0d ack=%b)", i,
                        {alarmActive, alarmCode, buzzer, nurseCall, eventCount}, expVec(), cur, a);
            bad++;
         end else passes++;
      end
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 0; i < 300; i++) begin
         step(6, 0);
         step(0, 1);
         repeat (HOLD) step(0, 0);
      end
      checks++;
`ifdef ALARM_EVENT_COUNTER_EN
      if (eventCount !== 8'd255) $display("FAIL count_saturate: got %0d expected 255", eventCount);
      else passes++;
`else
      if (eventCount !== 8'd0) $display("FAIL count_disabled: got %0d expected 0", eventCount);
      else passes++;
`endif
      checks++;
      if ({alarmActive, alarmCode, buzzer, nurseCall, eventCount} !== expVec())
         $display("FAIL count_model: got %h expected %h", {alarmActive, alarmCode, buzzer, nurseCall, eventCount}, expVec());
      else passes++;
   endtask

   initial begin
      test_reset();
      test_persistence();
      test_escalation();
      test_upgrade();
      test_holdoff();
      test_ack_wins();
      test_critical_reset();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/healthcare_alarm_dispatcher.md
HEALTHCARE_ALARM_DISPATCHER -- requirements
Module: healthcare_alarm_dispatcher

Interface
REQ-001 SHALL provide parameter PERSIST_CYCLES, default 4: consecutive identical nonzero samples needed to latch an alarm.
REQ-002 SHALL provide parameter ESC_CYCLES, default 16: cycles in ALARM without acknowledge before escalation.
REQ-003 SHALL provide parameter HOLDOFF_CYCLES, default 8: cycles after acknowledge during which same-or-lower codes are suppressed.
REQ-004 SHALL provide parameter BUZZ_DIV, default 2: buzzer half-period in cycles while in ALARM.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have these ports:
- clock  in  1  rising-edge system clock
- resetN  in  1  asynchronous active-low reset
- abnormalityWarning  in  3  upstream severity code, 0 = none, 1..6 increasing severity; 7 treated as 6
- acknowledge  in  1  caregiver acknowledge, sampled level
- alarmActive  out  1  alarm latched (ALARM or ESCALATED)
- alarmCode  out  3  latched severity, 0 when no alarm
- buzzer  out  1  audible drive
- nurseCall  out  1  escalation request
- eventCount  out  8  saturating count of latched/upgraded alarms

Function
REQ-007 SHALL implement states IDLE, QUALIFY, ALARM, ESCALATED, HOLDOFF; all outputs registered (Moore).
REQ-008 IDLE: nonzero code 1..5 -> QUALIFY with qualCode = code, qualCnt = 1; code 0 -> stay.
REQ-009 QUALIFY: same code -> qualCnt+1; when the PERSIST_CYCLES-th consecutive sample is taken -> ALARM, alarmCode = qualCode; different nonzero code -> restart with qualCnt = 1; code 0 -> IDLE.
REQ-010 Code 6 (or 7) sampled in IDLE, QUALIFY or HOLDOFF SHALL enter ALARM at that edge with alarmCode = 6, bypassing persistence.
REQ-011 ALARM: escTimer counts from 0 each cycle; alarm stays latched when input returns to 0; acknowledge -> HOLDOFF; escTimer reaching ESC_CYCLES-1 without acknowledge -> ESCALATED.
REQ-012 ALARM/ESCALATED: input code > alarmCode SHALL upgrade alarmCode at the next edge without persistence; escTimer not reset; lower codes ignored.
REQ-013 ESCALATED: nurseCall = 1, buzzer steady 1; leaves only on acknowledge -> HOLDOFF.
REQ-014 ALARM: buzzer toggles every BUZZ_DIV cycles, starting at 1 on entry; 0 in all other states except ESCALATED.
REQ-015 On acknowledge edge: ackedCode = alarmCode; alarmActive, alarmCode, buzzer, nurseCall cleared at the same edge; acknowledge and upgrade in same cycle -> acknowledge wins, ackedCode = pre-upgrade alarmCode.
REQ-016 HOLDOFF: input code > ackedCode SHALL go to QUALIFY (or ALARM if 6) at that edge; otherwise after HOLDOFF_CYCLES cycles -> IDLE.
REQ-017 Acknowledge in IDLE, QUALIFY or HOLDOFF SHALL have no effect.
REQ-018 eventCount SHALL increment by 1 on every ALARM entry and every upgrade, saturating at 255.

Reset
REQ-019 resetN low SHALL asynchronously force IDLE, all counters 0, ackedCode 0, all outputs 0; reset mid-alarm discards the alarm.
REQ-020 First state change after release SHALL occur no earlier than the first rising edge with resetN high.

Configuration
REQ-021 With ALARM_EVENT_COUNTER_EN defined, eventCount SHALL behave per REQ-018; without it, eventCount SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-022 Code 3 held 4 cycles from IDLE -> alarmActive = 1, alarmCode = 3 at 4th edge; code 3 held 3 cycles then 0 -> no alarm.
REQ-023 Code 5 latched, no acknowledge for 16 cycles -> nurseCall = 1, buzzer steady 1; acknowledge -> all outputs 0 next edge.
REQ-024 Code 2 latched, then code 4 -> alarmCode = 4 next edge, eventCount = 2.
REQ-025 Acknowledge code 4 alarm, then code 4 during HOLDOFF -> suppressed; code 5 during HOLDOFF -> QUALIFY, alarm 5 after 4 samples.
REQ-026 Code 6 single cycle from IDLE -> alarmCode = 6 at that edge; resetN low mid-ALARM -> outputs 0 immediately, IDLE.
REQ-027 300 alarm/acknowledge cycles with macro defined -> eventCount = 255; without macro -> eventCount = 0.
